// File: rtl/word_align.sv
// word_align: receive-side word aligner for the SERDES link.
// Hunts the sync byte with bit-slip pulses, then declares lock.
module word_align #(
  parameter logic [7:0]  SYNC_WORD  = 8'hF6,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned SLIP_WAIT  = 4
) (
  input  logic       pclk,
  input  logic       Rs_n,
  input  logic [7:0] rx_dat,
  input  logic       cal,
  input  logic       recal,
  input  logic       train,
  output logic       bit_slip,
  output logic       aligned,
  output logic       align_err,
  output logic [2:0] slip_cnt,
  output logic [7:0] dat_out,
  output logic       dat_vld
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_WAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [3:0] WAIT_N   = 4'(SLIP_WAIT);

  state_t     state_q, state_d;
  logic [7:0] r_dat_q;
  logic [3:0] match_q, match_d;
  logic [3:0] miss_q, miss_d;
  logic [2:0] slip_q, slip_d;
  logic [3:0] wait_q, wait_d;
  logic       bit_slip_q, bit_slip_d;
  logic       aligned_q, aligned_d;
  logic       align_err_q, align_err_d;
  logic       hit;
  logic       run;

  assign hit = (r_dat_q == SYNC_WORD);
  assign run = cal && !recal;

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    slip_d  = slip_q;
    wait_d  = wait_q;
    if (!run) begin
      state_d = S_IDLE;
      match_d = '0;
      miss_d  = '0;
      slip_d  = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          match_d = '0;
          miss_d  = '0;
          slip_d  = '0;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (hit) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N)
              state_d = S_LOCKED;
          end else begin
            match_d = '0;
            state_d = (slip_q == 3'd7) ? S_FAIL : S_SLIP;
          end
        end
        S_SLIP: begin
          slip_d  = slip_q + 3'd1;
          wait_d  = WAIT_N;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wait_d = wait_q - 4'd1;
          if (wait_q <= 4'd1) begin
            wait_d  = '0;
            match_d = '0;
            state_d = S_CHECK;
          end
        end
        S_LOCKED: begin
          // payload outside training is arbitrary: hold miss count
          if (train) begin
            if (hit) begin
              miss_d = '0;
            end else if (miss_q + 4'd1 == UNLOCK_N) begin
              miss_d  = '0;
              match_d = '0;
              state_d = S_CHECK;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_slip_d  = run && (state_q == S_SLIP);
    aligned_d   = run && (state_q == S_LOCKED);
    align_err_d = recal ? 1'b0
                : (align_err_q || (state_q == S_FAIL));
  end

  always_ff @(posedge pclk or negedge Rs_n) begin
    if (!Rs_n) begin
      state_q     <= S_IDLE;
      r_dat_q     <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      slip_q      <= '0;
      wait_q      <= '0;
      bit_slip_q  <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_dat_q     <= rx_dat;
      match_q     <= match_d;
      miss_q      <= miss_d;
      slip_q      <= slip_d;
      wait_q      <= wait_d;
      bit_slip_q  <= bit_slip_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
    end
  end

  assign bit_slip  = bit_slip_q;
  assign aligned   = aligned_q;
  assign align_err = align_err_q;
  assign slip_cnt  = slip_q;
  assign dat_out   = r_dat_q;
  assign dat_vld   = aligned_q;

endmodule

// File: tb/tb_word_align.sv
// tb_word_align: scoreboard bench for word_align.
// A serial-stream model reacts to bit_slip; expected events are queued.
module tb_word_align;

  localparam logic [7:0] SYNC = 8'hF6;
  localparam int K_SLIP   = 0;
  localparam int K_LOCK   = 1;
  localparam int K_UNLOCK = 2;
  localparam int K_ERR    = 3;

  logic       pclk = 1'b0;
  logic       Rs_n;
  logic [7:0] rx_dat;
  logic       cal, recal, train;
  logic       bit_slip, aligned, align_err, dat_vld;
  logic [2:0] slip_cnt;
  logic [7:0] dat_out;

  word_align dut (
    .pclk      (pclk),
    .Rs_n      (Rs_n),
    .rx_dat    (rx_dat),
    .cal       (cal),
    .recal     (recal),
    .train     (train),
    .bit_slip  (bit_slip),
    .aligned   (aligned),
    .align_err (align_err),
    .slip_cnt  (slip_cnt),
    .dat_out   (dat_out),
    .dat_vld   (dat_vld)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         kind;
    int         at;
    logic [2:0] sc;
  } ev_t;
  ev_t expq[$];

  task automatic push(input int k, input int at, input int sc);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.sc   = 3'(sc);
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // serial source: repeating SYNC seen through a bit offset
  int         mode = 0;
  int         off  = 0;
  logic [7:0] cval = 8'h00;

  function automatic logic [7:0] rotl(input logic [7:0] w,
                                      input int n);
    logic [15:0] d;
    d = {w, w};
    return d[15-n -: 8];
  endfunction

  always @(negedge pclk) begin
    if (bit_slip === 1'b1) off = (off + 7) % 8;
    case (mode)
      0:       rx_dat = rotl(SYNC, off);
      1:       rx_dat = cval;
      default: rx_dat = 8'($urandom);
    endcase
  end

  // monitor: every observed event must match the queue head
  logic pa = 1'b0;
  logic pe = 1'b0;

  task automatic got(input int k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d at cyc %0d sc %0d",
               k, cyc, slip_cnt);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.at != cyc || e.sc !== slip_cnt) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d sc %0d want kind %0d cyc %0d sc %0d",
                 k, cyc, slip_cnt, e.kind, e.at, e.sc);
      end
    end
  endtask

  always @(negedge pclk) begin
    if (Rs_n === 1'b1) begin
      if (bit_slip) got(K_SLIP);
      if (aligned && !pa) got(K_LOCK);
      if (!aligned && pa) got(K_UNLOCK);
      if (align_err && !pe) got(K_ERR);
    end
    pa = aligned;
    pe = align_err;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, ".bit_slip"}, 32'(bit_slip), 0);
    chk({nm, ".aligned"}, 32'(aligned), 0);
    chk({nm, ".align_err"}, 32'(align_err), 0);
    chk({nm, ".slip_cnt"}, 32'(slip_cnt), 0);
    chk({nm, ".dat_vld"}, 32'(dat_vld), 0);
  endtask

  initial begin
    int e0;
    int p;
    Rs_n  = 1'b1;
    cal   = 1'b0;
    recal = 1'b0;
    train = 1'b1;
    #2 Rs_n = 1'b0;
    repeat (3) tick();
    idle_chk("reset");
    chk("reset.dat_out", 32'(dat_out), 0);
    Rs_n = 1'b1;
    tick();

    // already aligned
    off = 0; mode = 0;
    tick();
    cal = 1'b1;
    e0 = cyc + 1;
    push(K_LOCK, e0 + 5, 0);
    repeat (10) tick();
    chk("aligned.aligned", 32'(aligned), 1);
    chk("aligned.slip_cnt", 32'(slip_cnt), 0);
    chk("aligned.dat_vld", 32'(dat_vld), 1);
    chk("aligned.dat_out", 32'(dat_out), 32'(SYNC));

    // lock loss: three bad words while training
    p = cyc;
    mode = 1; cval = 8'h00;
    repeat (3) tick();
    mode = 0;
    push(K_UNLOCK, p + 5, 0);
    push(K_LOCK, p + 9, 0);
    repeat (4) tick();
    chk("loss.aligned_low", 32'(aligned), 0);
    chk("loss.slip_cnt", 32'(slip_cnt), 0);
    repeat (4) tick();
    chk("loss.relock", 32'(aligned), 1);

    // payload: random words with train=0 keep lock
    train = 1'b0; mode = 2;
    repeat (10) tick();
    chk("payload.aligned", 32'(aligned), 1);
    mode = 0;
    repeat (2) tick();
    train = 1'b1;
    repeat (3) tick();
    chk("payload.after", 32'(aligned), 1);

    // cal drop while locked
    cal = 1'b0;
    push(K_UNLOCK, cyc + 1, 0);
    repeat (3) tick();
    idle_chk("caldrop_lock");

    // offset 3
    off = 3; mode = 0;
    repeat (2) tick();
    cal = 1'b1;
    e0 = cyc + 1;
    for (int j = 0; j < 3; j++) push(K_SLIP, e0 + 2 + 6 * j, j + 1);
    push(K_LOCK, e0 + 23, 3);
    repeat (30) tick();
    chk("offset3.aligned", 32'(aligned), 1);
    chk("offset3.slip_cnt", 32'(slip_cnt), 3);
    cal = 1'b0;
    push(K_UNLOCK, cyc + 1, 0);
    repeat (3) tick();

    // never matching
    mode = 1; cval = 8'h00;
    repeat (2) tick();
    cal = 1'b1;
    e0 = cyc + 1;
    for (int j = 0; j < 7; j++) push(K_SLIP, e0 + 2 + 6 * j, j + 1);
    push(K_ERR, e0 + 44, 7);
    repeat (50) tick();
    chk("nomatch.align_err", 32'(align_err), 1);
    chk("nomatch.aligned", 32'(aligned), 0);
    chk("nomatch.slip_cnt", 32'(slip_cnt), 7);
    cal = 1'b0;
    repeat (2) tick();
    chk("nomatch.err_kept", 32'(align_err), 1);
    cal = 1'b1; recal = 1'b1;
    p = cyc + 1;
    push(K_SLIP, p + 3, 1);
    tick();
    recal = 1'b0;
    chk("recal.align_err", 32'(align_err), 0);
    chk("recal.slip_cnt", 32'(slip_cnt), 0);
    repeat (3) tick();
    cal = 1'b0;
    repeat (3) tick();

    // cal drop during WAIT
    off = 2; mode = 0;
    repeat (2) tick();
    cal = 1'b1;
    e0 = cyc + 1;
    push(K_SLIP, e0 + 2, 1);
    repeat (4) tick();
    cal = 1'b0;
    repeat (3) tick();
    idle_chk("caldrop_wait");

    // async reset while bit_slip is high
    off = 5;
    repeat (2) tick();
    cal = 1'b1;
    repeat (3) tick();
    chk("rst.slip_before", 32'(bit_slip), 1);
    Rs_n = 1'b0;
    #1;
    chk("rst.slip_async", 32'(bit_slip), 0);
    chk("rst.slip_cnt", 32'(slip_cnt), 0);
    cal = 1'b0;
    tick();
    Rs_n = 1'b1;
    repeat (5) tick();

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d events left want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
